// File: rtl/i2c_slave_wr.sv
// Write-only I2C slave.
// SCL/SDA are oversampled by clk through two-flop synchronizers plus one
// delay stage. START/STOP are detected from the synchronized copies. The
// slave ACKs a matching write address and every following data byte, and
// hands each received byte to the core on a single-cycle rx_valid strobe.
// Read requests and foreign addresses are NACKed by never driving SDA.
module i2c_slave_wr #(
   parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_o,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic [7:0] rx_idx,
   output logic       busy,
   output logic       stop_det
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_DATA     = 3'd3,
      ST_DATA_ACK = 3'd4,
      ST_IGNORE   = 3'd5
   } state_t;

   // Pipe bit 0 is the metastable stage, bit 1 the synchronized value,
   // bit 2 the synchronized value one cycle older (for edge detection).
   logic [2:0] scl_pipe_reg;
   logic [2:0] sda_pipe_reg;

   logic scl_sync;
   logic scl_dly;
   logic sda_sync;
   logic sda_dly;

   logic scl_rise;
   logic scl_fall;
   logic start_ev;
   logic stop_ev;
   logic byte_done;
   logic [7:0] byte_val;

   state_t state_reg;
   state_t state_next;

   // The first seven bits of a byte live here; the eighth is taken straight
   // from the bus on the completing edge, so the full byte is byte_val.
   logic [6:0] shift_reg;
   logic [6:0] shift_next;
   logic [2:0] bit_cnt_reg;
   logic [2:0] bit_cnt_next;
   logic       sda_reg;
   logic       sda_next;
   logic [7:0] rx_data_reg;
   logic [7:0] rx_data_next;
   logic       rx_valid_reg;
   logic       rx_valid_next;
   logic [7:0] rx_idx_reg;
   logic [7:0] rx_idx_next;
   logic       busy_reg;
   logic       busy_next;
   logic       stop_det_reg;
   logic       stop_det_next;

   // Bring the asynchronous bus lines into the clk domain; reset to an idle
   // (high) bus so that reset release can never look like a START.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_pipe_reg <= 3'b111;
         sda_pipe_reg <= 3'b111;
      end else begin
         scl_pipe_reg <= {scl_pipe_reg[1:0], scl_i};
         sda_pipe_reg <= {sda_pipe_reg[1:0], sda_i};
      end
   end

   assign scl_sync = scl_pipe_reg[1];
   assign scl_dly  = scl_pipe_reg[2];
   assign sda_sync = sda_pipe_reg[1];
   assign sda_dly  = sda_pipe_reg[2];

   assign scl_rise  = scl_sync & ~scl_dly;
   assign scl_fall  = ~scl_sync & scl_dly;
   assign start_ev  = scl_sync & sda_dly & ~sda_sync;
   assign stop_ev   = scl_sync & ~sda_dly & sda_sync;
   assign byte_val  = {shift_reg, sda_sync};
   assign byte_done = scl_rise && (bit_cnt_reg == 3'd7);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; bus START/STOP override any bit-level progress.
   always_comb begin
      state_next = state_reg;
      if (start_ev) begin
         state_next = ST_ADDR;
      end else if (stop_ev) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_next = ST_IDLE;
            end
            ST_ADDR: begin
               if (byte_done) begin
                  if ((byte_val[7:1] == SLAVE_ADDR) && !byte_val[0]) begin
                     state_next = ST_ADDR_ACK;
                  end else begin
                     state_next = ST_IGNORE;
                  end
               end
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
               // Second falling edge while holding SDA low ends the ACK bit.
               if (scl_fall && !sda_reg) begin
                  state_next = ST_DATA;
               end
            end
            ST_DATA: begin
               if (byte_done) begin
                  state_next = ST_DATA_ACK;
               end
            end
            ST_IGNORE: begin
               state_next = ST_IGNORE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Output and datapath logic: bit shifting, ACK drive, byte strobe,
   // byte index and busy/stop flags.
   always_comb begin
      shift_next    = shift_reg;
      bit_cnt_next  = bit_cnt_reg;
      sda_next      = sda_reg;
      rx_data_next  = rx_data_reg;
      rx_valid_next = 1'b0;
      rx_idx_next   = rx_idx_reg;
      busy_next     = busy_reg;
      stop_det_next = 1'b0;
      if (start_ev) begin
         // START or repeated START: abandon any partial byte or ACK.
         bit_cnt_next = 3'd0;
         sda_next     = 1'b1;
         busy_next    = 1'b0;
      end else if (stop_ev) begin
         bit_cnt_next  = 3'd0;
         sda_next      = 1'b1;
         busy_next     = 1'b0;
         stop_det_next = 1'b1;
      end else begin
         case (state_reg)
            ST_ADDR, ST_DATA: begin
               if (scl_rise) begin
                  shift_next   = byte_val[6:0];
                  bit_cnt_next = bit_cnt_reg + 3'd1;
               end
               if ((state_reg == ST_DATA) && byte_done) begin
                  rx_data_next  = byte_val;
                  rx_valid_next = 1'b1;
               end
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
               // SDA only moves on SCL falling edges, so it is stable
               // whenever the master samples it with SCL high.
               if (scl_fall) begin
                  if (sda_reg) begin
                     sda_next = 1'b0;
                  end else begin
                     sda_next     = 1'b1;
                     bit_cnt_next = 3'd0;
                     if (state_reg == ST_ADDR_ACK) begin
                        busy_next   = 1'b1;
                        rx_idx_next = 8'd0;
                     end else begin
                        rx_idx_next = rx_idx_reg + 8'd1;
                     end
                  end
               end
            end
            default: begin
               sda_next = 1'b1;
            end
         endcase
      end
   end

   // Datapath and output registers; async reset releases SDA at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg    <= 7'd0;
         bit_cnt_reg  <= 3'd0;
         sda_reg      <= 1'b1;
         rx_data_reg  <= 8'h00;
         rx_valid_reg <= 1'b0;
         rx_idx_reg   <= 8'h00;
         busy_reg     <= 1'b0;
         stop_det_reg <= 1'b0;
      end else begin
         shift_reg    <= shift_next;
         bit_cnt_reg  <= bit_cnt_next;
         sda_reg      <= sda_next;
         rx_data_reg  <= rx_data_next;
         rx_valid_reg <= rx_valid_next;
         rx_idx_reg   <= rx_idx_next;
         busy_reg     <= busy_next;
         stop_det_reg <= stop_det_next;
      end
   end

   assign sda_o    = sda_reg;
   assign rx_data  = rx_data_reg;
   assign rx_valid = rx_valid_reg;
   assign rx_idx   = rx_idx_reg;
   assign busy     = busy_reg;
   assign stop_det = stop_det_reg;

endmodule
